ctr_prog_arb: RTL



---
 rtl/ctr_prog_pkg.sv | 40 ++++
 rtl/rr_arb.sv | 48 ++++
 rtl/ctr_prog_arb.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ctr_prog_pkg.sv
// Shared types for the counter programming sequencer: FSM states, write-mask
// bit positions and the helper that walks the fixed FRQ -> PHS -> CTR order.
package ctr_prog_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WFRQ = 3'd1,
    WPHS = 3'd2,
    WCTR = 3'd3,
    ACK  = 3'd4
  } state_e;

  localparam int MB_CTR = 0;
  localparam int MB_FRQ = 1;
  localparam int MB_PHS = 2;

  // Next enabled write state after 'cur'; FRQ and PHS always land before CTR
  // so a mode change never runs with a stale rate or phase.
  function automatic state_e next_write(input logic [2:0] mask, input state_e cur);
    state_e nxt;
    nxt = ACK;
    case (cur)
      IDLE: begin
        if (mask[MB_FRQ])      nxt = WFRQ;
        else if (mask[MB_PHS]) nxt = WPHS;
        else if (mask[MB_CTR]) nxt = WCTR;
      end
      WFRQ: begin
        if (mask[MB_PHS])      nxt = WPHS;
        else if (mask[MB_CTR]) nxt = WCTR;
      end
      WPHS: begin
        if (mask[MB_CTR])      nxt = WCTR;
      end
      default: nxt = ACK;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: combinational winner search starting at a registered
// pointer; the pointer moves to one past the served index when advanced.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  input  logic [IDXW-1:0] adv_idx_i,
  output logic            vld_o,
  output logic [IDXW-1:0] win_o
);

  logic [IDXW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = (adv_idx_i == IDXW'(NREQ - 1)) ? '0 : adv_idx_i + 1'b1;
    end
  end

  // Scan from farthest to nearest so the nearest set bit at/after ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    vld_o = 1'b0;
    win_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (req_i[idx]) begin
        vld_o = 1'b1;
        win_o = IDXW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ctr_prog_arb.sv
// Programming sequencer for one cog counter: arbitrates requesters and issues
// one register write per cycle (FRQ, PHS, CTR) from latched shadow values.
module ctr_prog_arb
  import ctr_prog_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic               clk_cog,
  input  logic               nres,
  input  logic [NREQ-1:0]    req,
  input  logic [3*NREQ-1:0]  wmask,
  input  logic [32*NREQ-1:0] ctr_val,
  input  logic [32*NREQ-1:0] frq_val,
  input  logic [32*NREQ-1:0] phs_val,
  output logic [NREQ-1:0]    ack,
  output logic               busy,
  output logic [IDXW-1:0]    owner,
  output logic               setctr,
  output logic               setfrq,
  output logic               setphs,
  output logic [31:0]        data
);

  state_e          state_q, state_d;
  logic [2:0]      mask_q, mask_d;
  logic [31:0]     ctr_q, ctr_d;
  logic [31:0]     frq_q, frq_d;
  logic [31:0]     phs_q, phs_d;
  logic [IDXW-1:0] owner_q, owner_d;

  logic            setctr_q, setctr_d;
  logic            setfrq_q, setfrq_d;
  logic            setphs_q, setphs_d;
  logic [31:0]     data_q, data_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] ack_q, ack_d;

  logic            win_vld;
  logic [IDXW-1:0] win_idx;

  rr_arb #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_arb (
    .clk_i     (clk_cog),
    .rst_ni    (nres),
    .req_i     (req),
    .adv_i     (state_q == ACK),
    .adv_idx_i (owner_q),
    .vld_o     (win_vld),
    .win_o     (win_idx)
  );

  // Sequencer next state; shadow registers load only on a grant from IDLE.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ctr_d   = ctr_q;
    frq_d   = frq_q;
    phs_d   = phs_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          mask_d  = wmask[3*win_idx +: 3];
          ctr_d   = ctr_val[32*win_idx +: 32];
          frq_d   = frq_val[32*win_idx +: 32];
          phs_d   = phs_val[32*win_idx +: 32];
          state_d = next_write(mask_d, IDLE);
        end
      end
      WFRQ, WPHS, WCTR: state_d = next_write(mask_q, state_q);
      ACK:              state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    setfrq_d = (state_d == WFRQ);
    setphs_d = (state_d == WPHS);
    setctr_d = (state_d == WCTR);
    busy_d   = (state_d != IDLE);
    ack_d    = '0;
    if (state_d == ACK) begin
      ack_d[owner_d] = 1'b1;
    end
    data_d = '0;
    case (state_d)
      WFRQ:    data_d = frq_d;
      WPHS:    data_d = phs_d;
      WCTR:    data_d = ctr_d;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      ctr_q    <= '0;
      frq_q    <= '0;
      phs_q    <= '0;
      owner_q  <= '0;
      setctr_q <= 1'b0;
      setfrq_q <= 1'b0;
      setphs_q <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ctr_q    <= ctr_d;
      frq_q    <= frq_d;
      phs_q    <= phs_d;
      owner_q  <= owner_d;
      setctr_q <= setctr_d;
      setfrq_q <= setfrq_d;
      setphs_q <= setphs_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
    end
  end

  assign ack    = ack_q;
  assign busy   = busy_q;
  assign owner  = owner_q;
  assign setctr = setctr_q;
  assign setfrq = setfrq_q;
  assign setphs = setphs_q;
  assign data   = data_q;

endmodule
